rs232c_tx_fifo: RTL and testbench

//  Transmit end of the RS232C path: accepts bytes pushed by the OUTPUTB dispatch (push_send_data/send_data),

---
 rtl/rs232c_pkg.sv | 27 ++
 rtl/rs232c_tx_fifo_if.sv | 20 ++
 rtl/rs232c_tx_queue.sv | 65 ++++++
 rtl/rs232c_tx_fifo.sv | 145 ++++++++++++++
 tb/tb_rs232c_tx_fifo.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/rs232c_pkg.sv
// ============================================================================
// Module : rs232c_pkg
// Brief  : Shared FSM encodings and frame constants for the RS232C TX path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs232c_pkg;

    localparam logic [15:0] c_DEFAULT_WAIT_CYCLES = 16'd573;
    localparam int          c_DATA_BITS           = 8;

`ifdef RS232C_TX_PARITY_EN
    localparam int          c_FRAME_BITS          = 11;
`else
    localparam int          c_FRAME_BITS          = 10;
`endif

    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_START  = 3'd1;
    localparam logic [2:0]  c_ST_DATA   = 3'd2;
    localparam logic [2:0]  c_ST_PARITY = 3'd3;
    localparam logic [2:0]  c_ST_STOP   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/rs232c_tx_fifo_if.sv
// ============================================================================
// Module : rs232c_tx_fifo_if
// Brief  : Dispatch-side bus of the RS232C transmitter (push/data in, status and tx out).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rs232c_tx_fifo_if;
    logic       push;
    logic [7:0] data;
    logic       full;
    logic       busy;
    logic       overflow;
    logic       tx;

    modport master (output push, data, input full, busy, overflow, tx);
    modport slave  (input push, data, output full, busy, overflow, tx);
endinterface

`default_nettype wire

// File: rtl/rs232c_tx_queue.sv
// ============================================================================
// Module : rs232c_tx_queue
// Brief  : Synchronous byte FIFO; rejects push when full, ignores pop when empty.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs232c_tx_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  i_push,
    input  wire logic [7:0]            i_data,
    input  wire logic                  i_pop,
    output logic [7:0]                 o_head,
    output logic [DEPTH_LOG2:0]        o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int                     c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]    c_FULL_COUNT = (DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0]    c_CNT_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0]  c_PTR_ONE    = DEPTH_LOG2'(1);

    logic [7:0]              r_mem [0:c_DEPTH-1];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic                    w_push_ok;
    logic                    w_pop_ok;

    // Room is judged on the registered count, so a same-cycle pop never frees a slot.
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop  & ~o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == c_FULL_COUNT);
    assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/rs232c_tx_fifo.sv
// ============================================================================
// Module : rs232c_tx_fifo
// Brief  : Buffered RS232C transmitter, 8N1 (8E1 when RS232C_TX_PARITY_EN is defined).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs232c_tx_fifo
    import rs232c_pkg::*;
#(
    parameter logic [15:0] WAIT_CYCLES = c_DEFAULT_WAIT_CYCLES,
    parameter int          DEPTH_LOG2  = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    rs232c_tx_fifo_if.slave bus
);

    logic [2:0]            r_state;
    logic [15:0]           r_timer;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shift;
    logic                  r_tx;
    logic                  r_overflow;
`ifdef RS232C_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic [7:0]            w_head;
    logic [DEPTH_LOG2:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_bit_end;

    assign w_pop     = (r_state == c_ST_IDLE) & ~w_empty;
    assign w_bit_end = (r_timer == WAIT_CYCLES - 16'd1);

    rs232c_tx_queue #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (bus.push),
        .i_data  (bus.data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
`ifdef RS232C_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            if (bus.push && w_full) r_overflow <= 1'b1;

            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_head;
`ifdef RS232C_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                        r_tx    <= 1'b0;
                        r_timer <= '0;
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= c_ST_DATA;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef RS232C_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= c_ST_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= c_ST_STOP;
`endif
                        end else begin
                            // The next bit is shift[1] before this shift lands.
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
`ifdef RS232C_TX_PARITY_EN
                c_ST_PARITY: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_tx    <= 1'b1;
                        r_state <= c_ST_STOP;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
`endif
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_tx    <= 1'b1;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign bus.full     = w_full;
    assign bus.busy     = (r_state != c_ST_IDLE) | (w_count != '0);
    assign bus.overflow = r_overflow;
    assign bus.tx       = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_rs232c_tx_fifo.sv
// ============================================================================
// Module : tb_rs232c_tx_fifo
// Brief  : Self-checking bench: directed pushes, frame decoder against a byte scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs232c_tx_fifo;
    import rs232c_pkg::*;

    localparam int W = 4;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [7:0] sb [$];

    rs232c_tx_fifo_if bus ();

    rs232c_tx_fifo #(
        .WAIT_CYCLES (16'd4),
        .DEPTH_LOG2  (2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one push cycle; returns #1 after the edge that samples it.
    task automatic do_push(input logic [7:0] d, input bit accepted);
        bus.push = 1'b1;
        bus.data = d;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        if (accepted) sb.push_back(d);
    endtask

    task automatic wait_idle(input int max_cycles);
        int i;
        i = 0;
        while ((bus.busy !== 1'b0 || sb.size() != 0) && i < max_cycles) begin
            @(posedge clk);
            #1;
            i++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_timeout", 32'(i < max_cycles), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("busy_after", 32'(bus.busy), 32'd0);
    endtask

    // Frame decoder: on a falling tx it pops the expected byte and checks every bit cycle.
    initial begin : g_monitor
        logic [10:0] exp_bits;
        logic [7:0]  d;
        bit          abort;
        logic        e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && bus.tx === 1'b0) begin
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_frame: observed start bit expected idle");
                end
                d = (sb.size() != 0) ? sb.pop_front() : 8'h00;
                exp_bits = '1;
                exp_bits[0]   = 1'b0;
                exp_bits[8:1] = d;
`ifdef RS232C_TX_PARITY_EN
                exp_bits[9]   = ^d;
`endif
                abort = 1'b0;
                for (int o = 0; o <= c_FRAME_BITS * W && !abort; o++) begin
                    if (o > 0) @(negedge clk);
                    if (reset !== 1'b0) begin
                        abort = 1'b1;
                    end else begin
                        e = (o == c_FRAME_BITS * W) ? 1'b1 : exp_bits[o / W];
                        tests++;
                        assert (bus.tx === e) else begin
                            fails++;
                            $error("FAIL frame_bit byte=%0h offset=%0d: observed %b expected %b",
                                   d, o, bus.tx, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : g_watchdog
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : g_stim
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        bus.push = 1'b0;
        bus.data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: reset state and quiet idle
        check("reset_state", 32'({bus.tx, bus.busy, bus.full, bus.overflow}), 32'b1000);
        repeat (50) begin
            @(posedge clk);
            #1;
            check("idle", 32'({bus.tx, bus.busy, bus.full, bus.overflow}), 32'b1000);
        end

        // 2: single byte, latency to start bit
        do_push(8'hA5, 1'b1);
        check("lat_accept_tx", 32'(bus.tx), 32'd1);
        check("lat_accept_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        check("lat_start_tx", 32'(bus.tx), 32'd0);
        wait_idle(200);

        // 3: three consecutive pushes, frames in order
        do_push(8'h00, 1'b1);
        do_push(8'hFF, 1'b1);
        do_push(8'h55, 1'b1);
        wait_idle(300);

        // 4: overfill a 4-deep FIFO
        do_push(8'h11, 1'b1);
        do_push(8'h22, 1'b1);
        do_push(8'h33, 1'b1);
        do_push(8'h44, 1'b1);
        check("full_at_3", 32'(bus.full), 32'd0);
        do_push(8'h66, 1'b1);
        check("full_at_4", 32'(bus.full), 32'd1);
        check("ovf_before", 32'(bus.overflow), 32'd0);
        do_push(8'h77, 1'b0);
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check("full_held", 32'(bus.full), 32'd1);
        wait_idle(500);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        check("full_drained", 32'(bus.full), 32'd0);

        // 5: reset in the middle of a data bit
        do_push(8'h3C, 1'b1);
        repeat (1 + W + 3 * W) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_state", 32'({bus.tx, bus.busy, bus.full, bus.overflow}), 32'b1000);
        repeat (60) begin
            @(posedge clk);
            #1;
            check("post_reset_quiet", 32'({bus.tx, bus.busy}), 32'b10);
        end

`ifdef RS232C_TX_PARITY_EN
        // 6: even parity on odd and even weight bytes
        do_push(8'h07, 1'b1);
        do_push(8'h03, 1'b1);
        wait_idle(300);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
